// File: rtl/gpu_led_pkg.sv
// Shared constants and helpers for the board LED driver.
package gpu_led_pkg;

  localparam int GPU_LED_NUM          = 10;
  localparam int GPU_LED_PRESCALE_50M = 50000;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int gpu_led_clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/gpu_led_stretch_cell.sv
// One LED lane: input register, rising-edge detect and
// pulse-stretch counter producing the lane's lit level.
module gpu_led_stretch_cell
  import gpu_led_pkg::*;
#(
  parameter int STRETCH_TICKS = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic stretch_en,
  input  logic led_in,
  output logic lit
);

  localparam int SW = gpu_led_clog2(STRETCH_TICKS + 1);
  localparam logic [SW-1:0] SLOAD = SW'(STRETCH_TICKS);

  logic          led_q, led_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          rise;

  always_comb begin
    led_d  = led_in;
    rise   = led_in & ~led_q;
    scnt_d = scnt_q;
    // A fresh edge reloads even when a tick lands in the same cycle.
    if (rise) begin
      scnt_d = SLOAD;
    end else if (tick && (scnt_q != '0)) begin
      scnt_d = scnt_q - SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      led_q  <= led_d;
      scnt_q <= scnt_d;
    end
  end

  assign lit = led_q | (stretch_en & (scnt_q != '0));

endmodule

// File: rtl/gpu_led_driver.sv
// Board LED driver: ms prescaler, blink gating, global PWM
// dimming and per-lane pulse stretching behind the LED PIO.
module gpu_led_driver
  import gpu_led_pkg::*;
#(
  parameter int NUM_LEDS      = GPU_LED_NUM,
  parameter int PRESCALE_DIV  = GPU_LED_PRESCALE_50M,
  parameter int PWM_BITS      = 4,
  parameter int STRETCH_TICKS = 50,
  parameter int BLINK_TICKS   = 250
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [NUM_LEDS-1:0] blink_mask,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                stretch_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                tick
);

  localparam int PW = gpu_led_clog2(PRESCALE_DIV);
  localparam int BW = gpu_led_clog2(BLINK_TICKS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  if (PRESCALE_DIV < 1 || BLINK_TICKS < 1 || STRETCH_TICKS < 1) begin : g_bad_cfg
    $error("gpu_led_driver: PRESCALE_DIV, BLINK_TICKS, STRETCH_TICKS must be >= 1");
  end

  logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
  logic                tick_q, tick_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;
  logic [NUM_LEDS-1:0] lit;
  logic                pwm_on;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    gpu_led_stretch_cell #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick_q),
      .stretch_en(stretch_en),
      .led_in    (led_in[i]),
      .lit       (lit[i])
    );
  end

  always_comb begin
    pre_cnt_d     = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PW'(1);
    tick_d        = (pre_cnt_q == PRE_LAST);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    // All-ones is forced on so full brightness has no dark slot.
    pwm_on    = (brightness == '1) | (pwm_cnt_q < brightness);
    led_out_d = lit & (~blink_mask | {NUM_LEDS{blink_phase_q}})
                    & {NUM_LEDS{pwm_on}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q     <= '0;
      tick_q        <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      pwm_cnt_q     <= '0;
      led_out_q     <= '0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      tick_q        <= tick_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_gpu_led_driver.sv
// Scoreboard bench for gpu_led_driver against a cycle-indexed
// arithmetic model of prescaler, blink, PWM and stretch timing.
module tb_gpu_led_driver;

  localparam int N   = 10;
  localparam int DIV = 4;
  localparam int ST  = 3;
  localparam int BT  = 2;
  localparam int PB  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  led_in = '0;
  logic [N-1:0]  blink_mask = '0;
  logic [PB-1:0] brightness = '0;
  logic          stretch_en = 1'b0;
  logic [N-1:0]  led_out;
  logic          tick;

  gpu_led_driver #(
    .NUM_LEDS(N), .PRESCALE_DIV(DIV), .PWM_BITS(PB),
    .STRETCH_TICKS(ST), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in),
    .blink_mask(blink_mask), .brightness(brightness),
    .stretch_en(stretch_en), .led_out(led_out), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] led;
    logic         tk;
    int           n;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int errors  = 0;

  // Model state: edges since reset release, last led_in, last rise edge.
  int           n_edge;
  logic [N-1:0] prev_in;
  int           last_rise [N];

  // Ticks visible at edges 2..x+1: tick is high before edge m
  // exactly when m-1 is a positive multiple of DIV.
  function automatic int nt(input int x);
    return (x < 0) ? 0 : x / DIV;
  endfunction

  function automatic int ticks(input int a, input int b);
    if (b < a) return 0;
    return nt(b - 1) - nt(a - 2);
  endfunction

  task automatic model_reset();
    n_edge  = 0;
    prev_in = '0;
    for (int i = 0; i < N; i++) last_rise[i] = -1;
  endtask

  task automatic model_edge();
    exp_t         e;
    logic [N-1:0] lit;
    logic         phase, pwm;
    int           s;
    n_edge++;
    for (int i = 0; i < N; i++) begin
      s = 0;
      if (last_rise[i] >= 0) begin
        s = ST - ticks(last_rise[i] + 1, n_edge - 1);
        if (s < 0) s = 0;
      end
      lit[i] = prev_in[i] | (stretch_en & (s != 0));
    end
    phase = ((ticks(1, n_edge - 1) / BT) % 2) == 0;
    pwm   = (brightness == 4'hF) || (((n_edge - 1) % 16) < int'(brightness));
    e.led = lit & (~blink_mask | {N{phase}}) & {N{pwm}};
    e.tk  = ((n_edge - 1) % DIV) == DIV - 1;
    e.n   = n_edge;
    q.push_back(e);
    for (int i = 0; i < N; i++)
      if (led_in[i] && !prev_in[i]) last_rise[i] = n_edge;
    prev_in = led_in;
  endtask

  task automatic step(input logic [N-1:0] li, input logic [N-1:0] m,
                      input logic [PB-1:0] br, input logic se);
    @(posedge clk);
    model_edge();
    #1;
    led_in     = li;
    blink_mask = m;
    brightness = br;
    stretch_en = se;
  endtask

  task automatic check_now(input string name, input logic [N-1:0] got,
                           input logic [N-1:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (led_out !== e.led || tick !== e.tk) begin
        errors++;
        $display("FAIL edge%0d: led_out %h tick %b want %h %b",
                 e.n, led_out, tick, e.led, e.tk);
      end
    end
  end

  initial begin
    logic [N-1:0]  li, m;
    logic [PB-1:0] br;
    logic          se;
    model_reset();
    led_in = 10'h3FF; brightness = 4'hF;
    repeat (3) begin
      @(negedge clk); #1;
      check_now("rst_led", led_out, '0);
      check_now("rst_tick", {9'b0, tick}, '0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Reset release, latency, blink start phase
    repeat (30) step(10'h3FF, '0, 4'hF, 1'b0);
    // PWM duty at 4, 0 and full
    repeat (40) step(10'h001, '0, 4'h4, 1'b0);
    repeat (20) step(10'h001, '0, 4'h0, 1'b0);
    repeat (20) step(10'h001, '0, 4'hF, 1'b0);
    // Blink masking
    repeat (40) step(10'h3FF, 10'h155, 4'hF, 1'b0);
    // Stretch: single pulses on lane 5 at every prescaler phase
    for (int k = 0; k < DIV; k++) begin
      repeat (k + 1) step(10'h000, '0, 4'hF, 1'b1);
      step(10'h020, '0, 4'hF, 1'b1);
      repeat (16) step(10'h000, '0, 4'hF, 1'b1);
    end
    // Re-trigger on lane 2 late in its stretch
    step(10'h004, '0, 4'hF, 1'b1);
    repeat (8) step(10'h000, '0, 4'hF, 1'b1);
    step(10'h004, '0, 4'hF, 1'b1);
    repeat (20) step(10'h000, '0, 4'hF, 1'b1);

    // Randomized traffic
    li = '0; m = '0; br = 4'hF; se = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      li = li ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 3) == 0) li = li & N'($urandom);
      if ($urandom_range(0, 49) == 0) m  = N'($urandom);
      if ($urandom_range(0, 19) == 0) br = PB'($urandom);
      if ($urandom_range(0, 39) == 0) se = 1'($urandom);
      step(li, m, br, se);
    end

    // Reset while lane 2 is mid-stretch
    step(10'h004, '0, 4'hF, 1'b1);
    repeat (3) step(10'h000, '0, 4'hF, 1'b1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_now("midrst_led", led_out, '0);
    check_now("midrst_tick", {9'b0, tick}, '0);
    @(negedge clk); #1;
    check_now("midrst_hold", led_out, '0);
    model_reset();
    reset_n = 1'b1;
    repeat (20) step(10'h000, '0, 4'hF, 1'b1);

    @(negedge clk); #1;
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
